switch_operand_capture: RTL and testbench

SWITCH_OPERAND_CAPTURE -- requirements
Module: switch_operand_capture

---
 rtl/entradas_pkg.sv | 10 +
 rtl/sync_debounce.sv | 40 ++++
 rtl/switch_operand_capture.sv | 54 +++++
 tb/tb_switch_operand_capture.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/entradas_pkg.sv
// entradas_pkg: capture FSM state type and default sizing for switch_operand_capture
package entradas_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_N_OPS     = 2;
  localparam int DEF_DB_CYCLES = 4;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchronizer feeding a whole-vector stable-count debouncer
module sync_debounce #(
  parameter int W         = 1,
  parameter int DB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_db,
  output logic         o_changed
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  logic [W-1:0]  r_s1, r_s2, r_prev, r_db;
  logic [CW-1:0] r_cnt, w_run;
  logic          r_changed, w_load;
  // w_run is the stable-run index including this cycle; a fresh value starts at 0
  always_comb begin
    w_run  = (r_s2 != r_prev) ? '0 : r_cnt + 1'b1;
    w_load = (r_s2 != r_db) && (w_run == LAST);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_prev    <= '0;
      r_db      <= '0;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_prev    <= r_s2;
      r_cnt     <= (r_s2 == r_db || w_load) ? '0 : w_run;
      r_db      <= w_load ? r_s2 : r_db;
      r_changed <= w_load;
    end
  assign o_db      = r_db;
  assign o_changed = r_changed;
endmodule

// File: rtl/switch_operand_capture.sv
// switch_operand_capture: latches the debounced switch bank as packed operands on each debounced button press
module switch_operand_capture
  import entradas_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_OPS     = DEF_N_OPS,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_OPS*WIDTH-1:0] sw,
  input  logic                   load_btn,
  output logic [N_OPS*WIDTH-1:0] ops,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sw_changed,
  output logic                   overrun
);
  localparam int SW = N_OPS * WIDTH;
  logic [SW-1:0] w_sw_db, r_ops;
  logic          w_btn_db, w_btn_chg, w_req, r_overrun;
  state_t        r_state;
  sync_debounce #(.W(SW), .DB_CYCLES(DB_CYCLES)) u_sw (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (sw),
    .o_db     (w_sw_db),
    .o_changed(sw_changed)
  );
  sync_debounce #(.W(1), .DB_CYCLES(DB_CYCLES)) u_btn (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (load_btn),
    .o_db     (w_btn_db),
    .o_changed(w_btn_chg)
  );
  // both terms are registered, so the request is a clean one-cycle pulse on a debounced rise
  assign w_req = w_btn_chg & w_btn_db;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_ops     <= '0;
      r_overrun <= 1'b0;
    end else if (r_state == IDLE) begin
      r_ops   <= w_req ? w_sw_db : r_ops;
      r_state <= w_req ? HOLD : IDLE;
    end else begin
      r_overrun <= r_overrun | w_req;
      r_state   <= out_ready ? IDLE : HOLD;
    end
  assign ops       = r_ops;
  assign out_valid = (r_state == HOLD);
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_switch_operand_capture.sv
// tb_switch_operand_capture: random and directed stimulus scored against a sample-history reference model
module tb_switch_operand_capture;
  localparam int W  = 16;
  localparam int DB = 4;
  logic          clk = 1'b0, rst = 1'b1;
  logic [W-1:0]  sw = 16'hFFFF, ops;
  logic          load_btn = 1'b0, out_ready = 1'b0;
  logic          out_valid, sw_changed, overrun;
  logic [11:0]   p_sw = 12'hABC, p_ops;
  logic          p_btn = 1'b0, p_rdy = 1'b0, p_valid, p_chg, p_ovr;
  int            total = 0, bad = 0;
  always #5 clk = ~clk;
  switch_operand_capture dut (
    .clk(clk), .rst(rst), .sw(sw), .load_btn(load_btn), .ops(ops), .out_valid(out_valid),
    .out_ready(out_ready), .sw_changed(sw_changed), .overrun(overrun)
  );
  switch_operand_capture #(.WIDTH(4), .N_OPS(3), .DB_CYCLES(DB)) dut_p (
    .clk(clk), .rst(rst), .sw(p_sw), .load_btn(p_btn), .ops(p_ops), .out_valid(p_valid),
    .out_ready(p_rdy), .sw_changed(p_chg), .overrun(p_ovr)
  );
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic press(input int n);
    load_btn = 1'b1;
    cyc(n);
    load_btn = 1'b0;
    cyc(DB + 4);
  endtask
  // Reference: a value becomes debounced once DB consecutive edge samples agree and differ from
  // the current debounced value, taking effect two edges after the last of those samples.
  logic [W-1:0] h_sw[$], exp_q[$], m_db;
  logic         h_btn[$], m_bdb, m_req, m_hold, m_ovr, m_chg, sw_ok, b_ok;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sw = {};
      h_btn = {};
      exp_q = {};
      for (int i = 0; i < DB + 2; i++) begin
        h_sw.push_back('0);
        h_btn.push_back(1'b0);
      end
      m_db = '0; m_bdb = 1'b0; m_req = 1'b0; m_hold = 1'b0; m_ovr = 1'b0; m_chg = 1'b0;
    end else begin
      h_sw.push_back(sw);
      h_btn.push_back(load_btn);
      void'(h_sw.pop_front());
      void'(h_btn.pop_front());
      if (m_hold) begin
        if (m_req) m_ovr = 1'b1;
        if (out_ready) m_hold = 1'b0;
      end else if (m_req) begin
        m_hold = 1'b1;
        exp_q.push_back(m_db);
      end
      sw_ok = 1'b1;
      b_ok = 1'b1;
      for (int i = 1; i < DB; i++) begin
        if (h_sw[i] != h_sw[0]) sw_ok = 1'b0;
        if (h_btn[i] != h_btn[0]) b_ok = 1'b0;
      end
      m_chg = sw_ok && (h_sw[0] != m_db);
      if (m_chg) m_db = h_sw[0];
      m_req = b_ok && (h_btn[0] != m_bdb) && h_btn[0];
      if (b_ok && (h_btn[0] != m_bdb)) m_bdb = h_btn[0];
    end
  end
  logic [W-1:0] cur_exp = '0;
  logic         prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      cur_exp = '0;
      prev_v = 1'b0;
    end else if (out_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL capture: unexpected out_valid with ops=%h, nothing expected", ops);
      end else cur_exp = exp_q.pop_front();
    end
    check("out_valid", W'(out_valid), W'(m_hold));
    check("overrun", W'(overrun), W'(m_ovr));
    check("sw_changed", W'(sw_changed), W'(m_chg));
    check("ops", ops, cur_exp);
    prev_v = out_valid;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int first, cnt, sw_t, bt_t;
    cyc(3);
    check("rst_ops", ops, '0);
    check("rst_valid", W'(out_valid), '0);
    check("rst_overrun", W'(overrun), '0);
    rst = 1'b0;
    cyc(DB + 1);
    check("rst_db_early", W'(sw_changed), '0);
    cyc(1);
    check("rst_db_ffff", W'(sw_changed), W'(1'b1));
    p_btn = 1'b1;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      cyc(1);
      if (p_valid) first = i;
    end
    check("p_wait", W'(first != 0), W'(1'b1));
    check("p_ops", W'(p_ops), W'(12'hABC));
    check("p_op0", W'(p_ops[3:0]), W'(4'hC));
    p_btn = 1'b0;
    sw = 16'h3C5A;
    cyc(DB + 4);
    press(DB + 2);
    cyc(20);
    check("cap_valid", W'(out_valid), W'(1'b1));
    check("cap_ops", ops, 16'h3C5A);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    check("cap_release", W'(out_valid), '0);
    cyc(DB + 4);
    sw = sw | 16'h0001;
    cyc(3);
    sw = 16'h3C5A;
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      cnt += int'(sw_changed);
    end
    check("glitch_pulses", W'(cnt), '0);
    sw = 16'h3C5B;
    cnt = 0;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (sw_changed && first == 0) first = i;
      cnt += int'(sw_changed);
    end
    check("held_pulses", W'(cnt), W'(1));
    check("held_cycle", W'(first), W'(DB + 2));
    sw = 16'h1234;
    cyc(DB + 4);
    press(DB + 2);
    check("ovr_before", W'(overrun), '0);
    press(DB + 2);
    check("ovr_set", W'(overrun), W'(1'b1));
    check("ovr_ops", ops, 16'h1234);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    sw = 16'h0BEE;
    cyc(DB + 4);
    press(DB + 2);
    check("ovr_next_ops", ops, 16'h0BEE);
    check("ovr_sticky", W'(overrun), W'(1'b1));
    rst = 1'b1;
    cyc(1);
    check("mid_valid", W'(out_valid), '0);
    check("mid_ops", ops, '0);
    check("mid_overrun", W'(overrun), '0);
    rst = 1'b0;
    cyc(30);
    check("mid_no_capture", W'(out_valid), '0);
    load_btn = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 30 && first == 0; i++) begin
      cyc(1);
      if (out_valid) first = i;
    end
    check("held_btn_cycle", W'(first), W'(DB + 3));
    out_ready = 1'b1;
    cyc(20);
    load_btn = 1'b0;
    check("held_btn_once", W'(out_valid), '0);
    sw_t = 0;
    bt_t = 0;
    for (int c = 0; c < 2500; c++) begin
      if (sw_t == 0) begin
        sw = ($urandom_range(0, 1) == 0) ? 16'($urandom) : {12'h0, 4'($urandom)};
        sw_t = $urandom_range(1, 10);
      end else sw_t--;
      if (bt_t == 0) begin
        load_btn = ~load_btn;
        bt_t = $urandom_range(1, 9);
      end else bt_t--;
      out_ready = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    rst = 1'b0;
    load_btn = 1'b0;
    out_ready = 1'b1;
    cyc(30);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
